inventory_reader: RTL and testbench

Read-side companion to the inventory update core. It reads the shared 256-entry inventory memory through its read port. It serves two requests:
- single-code quantity queries, shown on the panel with a low-stock flag;
- full-memory scans that stream every non-zero (code, quantity) pair to a downstream consumer using a valid/ready handshake.

It never writes memory.

---
 rtl/inv_pkg.sv | 19 +
 rtl/inventory_reader.sv | 139 +++++++++++++
 tb/tb_inventory_reader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_pkg.sv
// Shared inventory definitions: memory geometry, default low-stock threshold
// and the reader FSM state type.
package inv_pkg;

  localparam int INV_ADDR_W     = 8;
  localparam int INV_DATA_W     = 8;
  localparam int INV_LOW_THRESH = 5;

  typedef enum logic [2:0] {
    IDLE,
    Q_RD,
    Q_CHK,
    S_RD,
    S_CHK,
    S_EMIT,
    S_END
  } reader_state_t;

endpackage

// File: rtl/inventory_reader.sv
// Read-only client of the inventory memory: answers single-code quantity
// queries and streams every non-zero (code, quantity) pair during a scan.
module inventory_reader
  import inv_pkg::*;
#(
  parameter int ADDR_W     = INV_ADDR_W,
  parameter int DATA_W     = INV_DATA_W,
  parameter int LOW_THRESH = INV_LOW_THRESH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              query,
  input  logic              scan,
  input  logic [ADDR_W-1:0] code_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] qty_out,
  output logic              qty_valid,
  output logic              low_stock,
  output logic [ADDR_W-1:0] item_code,
  output logic [DATA_W-1:0] item_qty,
  output logic              item_valid,
  input  logic              item_ready,
  output logic [ADDR_W:0]   item_count,
  output logic              busy,
  output logic              scan_done
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  reader_state_t     state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              ptr_at_last;
  logic              rd_nonzero;

  // Low stock means "still some left, but fewer than the threshold".
  function automatic logic is_low_stock(input logic [DATA_W-1:0] q);
    return (q != '0) && (q < DATA_W'(LOW_THRESH));
  endfunction

  assign ptr_at_last = (ptr == PTR_LAST);
  assign rd_nonzero  = (rd_data != '0);
  assign busy        = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; query has priority over scan, pulses outside IDLE are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (query)     state_nxt = Q_RD;
        else if (scan) state_nxt = S_RD;
      end
      Q_RD:  state_nxt = Q_CHK;
      Q_CHK: state_nxt = IDLE;
      S_RD:  state_nxt = S_CHK;
      S_CHK: begin
        if (rd_nonzero)       state_nxt = S_EMIT;
        else if (ptr_at_last) state_nxt = S_END;
        else                  state_nxt = S_RD;
      end
      S_EMIT: begin
        if (item_valid && item_ready) state_nxt = ptr_at_last ? S_END : S_RD;
      end
      S_END:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: read strobe/address are registered on entry to a read state,
  // so rd_en is high for exactly one cycle with a stable address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      ptr        <= '0;
      qty_out    <= '0;
      qty_valid  <= 1'b0;
      low_stock  <= 1'b0;
      item_code  <= '0;
      item_qty   <= '0;
      item_valid <= 1'b0;
      item_count <= '0;
      scan_done  <= 1'b0;
    end else begin
      rd_en     <= 1'b0;
      scan_done <= (state == S_END);
      case (state)
        IDLE: begin
          if (query) begin
            rd_en   <= 1'b1;
            rd_addr <= code_in;
          end else if (scan) begin
            rd_en      <= 1'b1;
            rd_addr    <= '0;
            ptr        <= '0;
            item_count <= '0;
            qty_valid  <= 1'b0;
          end
        end
        Q_CHK: begin
          qty_out   <= rd_data;
          qty_valid <= 1'b1;
          low_stock <= is_low_stock(rd_data);
        end
        S_CHK: begin
          if (rd_nonzero) begin
            item_code  <= ptr;
            item_qty   <= rd_data;
            item_valid <= 1'b1;
            item_count <= item_count + (ADDR_W+1)'(1);
          end else if (!ptr_at_last) begin
            ptr     <= ptr + ADDR_W'(1);
            rd_en   <= 1'b1;
            rd_addr <= ptr + ADDR_W'(1);
          end
        end
        S_EMIT: begin
          if (item_valid && item_ready) begin
            item_valid <= 1'b0;
            if (!ptr_at_last) begin
              ptr     <= ptr + ADDR_W'(1);
              rd_en   <= 1'b1;
              rd_addr <= ptr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inventory_reader.sv
// Self-checking bench for inventory_reader with a behavioural memory and
// a specification-level reference for queries and scans.
module tb_inventory_reader;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LT = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          query = 1'b0;
  logic          scan = 1'b0;
  logic [AW-1:0] code_in = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] qty_out;
  logic          qty_valid;
  logic          low_stock;
  logic [AW-1:0] item_code;
  logic [DW-1:0] item_qty;
  logic          item_valid;
  logic          item_ready = 1'b0;
  logic [AW:0]   item_count;
  logic          busy;
  logic          scan_done;

  logic [DW-1:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  inventory_reader #(.ADDR_W(AW), .DATA_W(DW), .LOW_THRESH(LT)) dut (
    .clk(clk), .rst_n(rst_n), .query(query), .scan(scan), .code_in(code_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .qty_out(qty_out), .qty_valid(qty_valid), .low_stock(low_stock),
    .item_code(item_code), .item_qty(item_qty), .item_valid(item_valid),
    .item_ready(item_ready), .item_count(item_count), .busy(busy),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after the strobe.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = '0;
  endtask

  // Query with optional simultaneous scan, or a scan pulse while busy.
  task automatic do_query(input logic [AW-1:0] code, input bit with_scan, input bit scan_mid);
    int exp_q;
    int exp_low;
    exp_q   = int'(mem[code]);
    exp_low = (exp_q > 0 && exp_q < LT) ? 1 : 0;
    tick();
    query = 1'b1; scan = with_scan; code_in = code;
    tick();
    query = 1'b0; scan = scan_mid; code_in = AW'($urandom);
    check_eq("q_rd_en", rd_en, 1);
    check_eq("q_rd_addr", rd_addr, code);
    check_eq("q_busy", busy, 1);
    tick();
    scan = 1'b0;
    check_eq("q_rd_en_once", rd_en, 0);
    tick();
    check_eq("q_qty", qty_out, exp_q);
    check_eq("q_valid", qty_valid, 1);
    check_eq("q_low", low_stock, exp_low);
    check_eq("q_idle", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("q_no_scan", {busy, item_valid, scan_done}, 0);
    end
  endtask

  // Full scan against the list of non-zero entries of the model memory.
  task automatic run_scan(input int stall_item, input int stall_len, input bit rand_ready);
    int exp_code[$];
    int exp_qty[$];
    int got, stalls, reads, bad_addr, cyc, done_cyc, stall_left;
    bit hold;
    logic [AW-1:0] hold_code;
    logic [DW-1:0] hold_qty;
    for (int a = 0; a < 256; a++)
      if (mem[a] != 0) begin exp_code.push_back(a); exp_qty.push_back(int'(mem[a])); end
    got = 0; stalls = 0; reads = 0; bad_addr = 0; done_cyc = 0; stall_left = stall_len;
    hold = 1'b0; hold_code = '0; hold_qty = '0;
    tick();
    scan = 1'b1;
    tick();
    scan = 1'b0;
    cyc = 1;
    while (cyc < 3000 && done_cyc == 0) begin
      if (rand_ready) item_ready = 1'($urandom_range(0, 1));
      else            item_ready = !(got == stall_item && stall_left > 0);
      @(negedge clk);
      if (rd_en) begin
        if (rd_addr != AW'(reads)) bad_addr++;
        reads++;
      end
      if (scan_done) done_cyc = cyc;
      if (hold) begin
        check_eq("hold_valid", item_valid, 1);
        check_eq("hold_code", item_code, hold_code);
        check_eq("hold_qty", item_qty, hold_qty);
      end
      if (item_valid) begin
        if (item_ready) begin
          if (got < exp_code.size()) begin
            check_eq("item_code", item_code, exp_code[got]);
            check_eq("item_qty", item_qty, exp_qty[got]);
          end else begin
            check_eq("extra_item", got, exp_code.size());
          end
          got++;
          hold = 1'b0;
        end else begin
          stalls++;
          hold = 1'b1; hold_code = item_code; hold_qty = item_qty;
          if (stall_left > 0) stall_left--;
        end
      end else begin
        hold = 1'b0;
      end
      tick();
      cyc++;
    end
    check_eq("scan_timeout", (done_cyc != 0), 1);
    check_eq("scan_done_cyc", done_cyc, 514 + exp_code.size() + stalls);
    check_eq("items_seen", got, exp_code.size());
    check_eq("item_count", item_count, exp_code.size());
    check_eq("reads", reads, 256);
    check_eq("rd_addr_seq", bad_addr, 0);
    check_eq("scan_busy", busy, 0);
    check_eq("scan_qty_valid", qty_valid, 0);
    @(negedge clk);
    check_eq("done_single", scan_done, 0);
    tick();
  endtask

  initial begin
    bit found;
    clear_mem();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outs", {rd_en, qty_valid, low_stock, item_valid, busy, scan_done}, 0);
    check_eq("rst_qty", qty_out, 0);
    check_eq("rst_item", {item_code, item_qty}, 0);
    check_eq("rst_count", item_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed queries, including threshold boundaries and zero quantity.
    mem[8'h12] = 8'd7; mem[8'h03] = 8'd2; mem[8'h04] = 8'd0;
    mem[8'h20] = 8'd4; mem[8'h21] = 8'd5; mem[8'h22] = 8'd1;
    do_query(8'h12, 0, 0);
    do_query(8'h03, 0, 0);
    do_query(8'h04, 0, 0);
    do_query(8'h20, 0, 0);
    do_query(8'h21, 0, 0);
    do_query(8'h22, 0, 0);

    // Random queries over random contents.
    for (int a = 0; a < 256; a++) mem[a] = DW'($urandom_range(0, 9));
    for (int i = 0; i < 8; i++) do_query(AW'($urandom), 0, 0);

    // Query wins over simultaneous scan; scan during query ignored.
    do_query(AW'($urandom), 1, 0);
    do_query(AW'($urandom), 0, 1);

    // Directed scan, consumer always ready, then with a 10-cycle stall.
    clear_mem();
    mem[8'h00] = 8'd1; mem[8'h80] = 8'd9; mem[8'hFF] = 8'd255;
    run_scan(-1, 0, 0);
    run_scan(1, 10, 0);

    // Reset while the 0x80 item waits in S_EMIT.
    found = 1'b0;
    tick();
    scan = 1'b1; item_ready = 1'b1;
    tick();
    scan = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      if (item_valid && item_code == 8'h80) begin
        found = 1'b1; item_ready = 1'b0;
      end else begin
        item_ready = 1'b1;
        tick();
      end
    end
    check_eq("rst_found_80", found, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", item_valid, 0);
    check_eq("rst_mid_rd_en", rd_en, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_count", item_count, 0);
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_mid_no_done", scan_done, 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst_idle", {busy, scan_done, item_valid}, 0);
    end
    run_scan(-1, 0, 0);

    // Empty memory: pure 2-cycle-per-entry timing.
    clear_mem();
    run_scan(-1, 0, 0);

    // Random sparse memory with random consumer back-pressure.
    for (int a = 0; a < 256; a++)
      mem[a] = ($urandom_range(0, 7) == 0) ? DW'($urandom_range(1, 255)) : '0;
    mem[8'hFF] = DW'($urandom_range(1, 255));
    run_scan(-1, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
